output_holder: RTL and testbench



---
 rtl/output_holder.sv | 155 +++++++++++++++
 tb/tb_output_holder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_holder.sv
// Byte holding FIFO between the stream-cipher core and the output mux.
// Presents the oldest byte until the user acknowledges it on the asynchronous output_acknowledge pin.
package types_pkg;
    typedef enum logic [1:0] {
        O_EMPTY    = 2'd0,
        O_READY    = 2'd1,
        O_ACK_WAIT = 2'd2
    } output_holder_state_t;
endpackage

module output_holder
    import types_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           core_byte_in,
    input  logic                 core_byte_valid,
    output logic                 core_byte_ready,
    input  logic                 output_acknowledge,
    input  logic                 flush,
    output logic [7:0]           data_out,
    output output_holder_state_t output_holder_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]             mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_next_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ack_prev_r;
    logic                   ack_sync_s;
    logic                   ack_rise_s;
    logic                   push_s;
    logic                   pop_s;
    logic [7:0]             head_s;
    output_holder_state_t   state_r;
    logic [7:0]             data_out_r;

    assign ack_sync_s          = sync_r[SYNC_STAGES-1];
    assign ack_rise_s          = ack_sync_s & ~ack_prev_r;
    assign core_byte_ready     = (count_r < DEPTH_C);
    assign data_out            = data_out_r;
    assign output_holder_state = state_r;

    // Push/pop qualification, next count, and the byte that will be at the head after this edge.
    always_comb begin
        push_s       = core_byte_valid & core_byte_ready & ~flush;
        pop_s        = (state_r == O_READY) & ack_rise_s & ~flush;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
        // An empty FIFO receiving a byte this cycle has not stored it yet: bypass it.
        if ((count_r == ZERO_C) && push_s) begin
            head_s = core_byte_in;
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

    // Acknowledge synchroniser chain plus edge-detect flop; deliberately not cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r     <= {SYNC_STAGES{1'b0}};
            ack_prev_r <= 1'b0;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], output_acknowledge};
            ack_prev_r <= ack_sync_s;
        end
    end

    // Byte storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= core_byte_in;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= ZERO_C;
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

    // Presentation state machine with data_out registered on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= O_EMPTY;
            data_out_r <= 8'h00;
        end else if (flush) begin
            state_r    <= O_EMPTY;
            data_out_r <= 8'h00;
        end else begin
            case (state_r)
                O_EMPTY: begin
                    if (count_r != ZERO_C) begin
                        state_r    <= O_READY;
                        data_out_r <= mem_r[rd_ptr_r];
                    end
                end
                O_READY: begin
                    if (ack_rise_s) begin
                        state_r    <= O_ACK_WAIT;
                        data_out_r <= 8'h00;
                    end
                end
                O_ACK_WAIT: begin
                    // Leave only once the pin is seen low, so a held-high pin cannot pop twice.
                    if (!ack_sync_s) begin
                        if (count_next_s != ZERO_C) begin
                            state_r    <= O_READY;
                            data_out_r <= head_s;
                        end else begin
                            state_r    <= O_EMPTY;
                            data_out_r <= 8'h00;
                        end
                    end
                end
                default: begin
                    state_r    <= O_EMPTY;
                    data_out_r <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_holder.sv
// Directed and randomised self-checking bench for output_holder (DEPTH=2, SYNC_STAGES=2).
module tb_output_holder;
    import types_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           core_byte_in = 8'h00;
    logic                 core_byte_valid = 1'b0;
    logic                 core_byte_ready;
    logic                 output_acknowledge = 1'b0;
    logic                 flush = 1'b0;
    logic [7:0]           data_out;
    output_holder_state_t output_holder_state;

    int tests = 0;
    int fails = 0;

    output_holder #(.DEPTH(2), .SYNC_STAGES(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .core_byte_in        (core_byte_in),
        .core_byte_valid     (core_byte_valid),
        .core_byte_ready     (core_byte_ready),
        .output_acknowledge  (output_acknowledge),
        .flush               (flush),
        .data_out            (data_out),
        .output_holder_state (output_holder_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input output_holder_state_t st, input logic [7:0] d);
        check({tag, "_state"}, 32'(output_holder_state), 32'(st));
        check({tag, "_data"}, 32'(data_out), 32'(d));
    endtask

    // Pin pulse: pop lands at M+2, release takes effect at L+2.
    task automatic ack_cycle(input string tag, input logic [7:0] head,
                             input output_holder_state_t exp_st, input logic [7:0] exp_d);
        output_acknowledge = 1'b1;
        tick();
        tick();
        check_out({tag, "_m1"}, O_READY, head);
        tick();
        check_out({tag, "_m2"}, O_ACK_WAIT, 8'h00);
        output_acknowledge = 1'b0;
        tick();
        tick();
        check_out({tag, "_l1"}, O_ACK_WAIT, 8'h00);
        tick();
        check_out({tag, "_l2"}, exp_st, exp_d);
    endtask

    initial begin
        logic [7:0]           q[$];
        int                   sent;
        int                   got;
        int                   accepted;
        int                   pops;
        int                   cyc;
        logic                 prev_valid;
        logic                 prev_ready;
        output_holder_state_t prev_st;

        // Reset, with a push attempted while held in reset.
        core_byte_valid = 1'b1;
        core_byte_in    = 8'hFF;
        tick();
        tick();
        check_out("rst", O_EMPTY, 8'h00);
        check("rst_ready", 32'(core_byte_ready), 32'd1);
        core_byte_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        check_out("rst_nopush", O_EMPTY, 8'h00);

        // Single byte: push, present, acknowledge, release.
        core_byte_in    = 8'hA5;
        core_byte_valid = 1'b1;
        tick();
        core_byte_valid = 1'b0;
        check_out("a5_n", O_EMPTY, 8'h00);
        tick();
        check_out("a5_n1", O_READY, 8'hA5);
        ack_cycle("a5_ack", 8'hA5, O_EMPTY, 8'h00);

        // Back-to-back push into a two-entry holder: third byte stalls.
        core_byte_in    = 8'h11;
        core_byte_valid = 1'b1;
        tick();
        core_byte_in = 8'h22;
        tick();
        core_byte_in = 8'h33;
        check("b2b_full", 32'(core_byte_ready), 32'd0);
        check_out("b2b_head", O_READY, 8'h11);
        tick();
        check("b2b_stall", 32'(core_byte_ready), 32'd0);
        ack_cycle("b2b_ack1", 8'h11, O_READY, 8'h22);
        core_byte_valid = 1'b0;
        check("b2b_33_in", 32'(core_byte_ready), 32'd0);
        ack_cycle("b2b_ack2", 8'h22, O_READY, 8'h33);
        check("b2b_ready1", 32'(core_byte_ready), 32'd1);
        ack_cycle("b2b_ack3", 8'h33, O_EMPTY, 8'h00);

        // Pin held high for 20 cycles with two bytes queued pops exactly one.
        core_byte_in    = 8'h44;
        core_byte_valid = 1'b1;
        tick();
        core_byte_in = 8'h55;
        tick();
        core_byte_valid = 1'b0;
        check_out("hold_pre", O_READY, 8'h44);
        output_acknowledge = 1'b1;
        repeat (20) tick();
        check_out("hold_20", O_ACK_WAIT, 8'h00);
        check("hold_one_pop", 32'(core_byte_ready), 32'd1);
        output_acknowledge = 1'b0;
        tick();
        tick();
        tick();
        check_out("hold_rel", O_READY, 8'h55);
        ack_cycle("hold_ack", 8'h55, O_EMPTY, 8'h00);

        // Flush while full with a push presented.
        core_byte_in    = 8'h66;
        core_byte_valid = 1'b1;
        tick();
        core_byte_in = 8'h77;
        tick();
        check_out("fl_pre", O_READY, 8'h66);
        core_byte_in = 8'h88;
        flush        = 1'b1;
        tick();
        flush           = 1'b0;
        core_byte_valid = 1'b0;
        check_out("fl_now", O_EMPTY, 8'h00);
        check("fl_ready", 32'(core_byte_ready), 32'd1);
        tick();
        tick();
        check_out("fl_after", O_EMPTY, 8'h00);

        // Flush on an empty holder discards a push that would otherwise be accepted.
        core_byte_in    = 8'h99;
        core_byte_valid = 1'b1;
        flush           = 1'b1;
        tick();
        flush           = 1'b0;
        core_byte_valid = 1'b0;
        tick();
        tick();
        check_out("fl_drop", O_EMPTY, 8'h00);

        // Mid-operation reset with the pin held high across release.
        core_byte_in    = 8'hC3;
        core_byte_valid = 1'b1;
        tick();
        core_byte_valid = 1'b0;
        tick();
        check_out("mid_pre", O_READY, 8'hC3);
        output_acknowledge = 1'b1;
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", O_EMPTY, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check_out("hi_rel", O_EMPTY, 8'h00);
        core_byte_in    = 8'h5A;
        core_byte_valid = 1'b1;
        tick();
        core_byte_valid = 1'b0;
        tick();
        check_out("hi_5a", O_READY, 8'h5A);
        repeat (5) tick();
        check_out("hi_still", O_READY, 8'h5A);
        output_acknowledge = 1'b0;
        tick();
        tick();
        tick();
        check_out("hi_low", O_READY, 8'h5A);
        ack_cycle("hi_ack", 8'h5A, O_EMPTY, 8'h00);

        // 300 random bytes with random acknowledge timing against a queue model.
        sent = 0;
        got = 0;
        accepted = 0;
        pops = 0;
        cyc = 0;
        prev_valid = 1'b0;
        prev_ready = core_byte_ready;
        prev_st = output_holder_state;
        while ((got < 300) && (cyc < 20000)) begin
            tick();
            cyc++;
            if (prev_valid && prev_ready) begin
                q.push_back(core_byte_in);
                accepted++;
                core_byte_valid = 1'b0;
            end
            if ((prev_st == O_READY) && (output_holder_state == O_ACK_WAIT)) begin
                pops++;
            end
            check("rnd_ready", 32'(core_byte_ready), 32'((accepted - pops) < 2));
            if (!core_byte_valid && (sent < 300) && ($urandom_range(1, 0) == 1)) begin
                core_byte_in    = 8'($urandom);
                core_byte_valid = 1'b1;
                sent++;
            end
            if (!output_acknowledge && (output_holder_state == O_READY) &&
                ($urandom_range(2, 0) != 0)) begin
                if (q.size() == 0) begin
                    check("rnd_q_underflow", 32'(q.size()), 32'd1);
                end else begin
                    check("rnd_data", 32'(data_out), 32'(q.pop_front()));
                end
                got++;
                output_acknowledge = 1'b1;
            end else if (output_acknowledge && (output_holder_state == O_ACK_WAIT) &&
                         ($urandom_range(1, 0) == 1)) begin
                output_acknowledge = 1'b0;
            end
            prev_valid = core_byte_valid;
            prev_ready = core_byte_ready;
            prev_st    = output_holder_state;
        end
        check("rnd_got", 32'(got), 32'd300);
        check("rnd_sent", 32'(sent), 32'd300);
        check("rnd_q_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
